// File: rtl/ps2_scan_receiver_if.sv
// PS/2 receiver pin/consumer bundle: raw PS/2 lines in, FIFO head and status out.
// master = keyboard pins plus consumer logic, slave = ps2_scan_receiver.
interface ps2_scan_receiver_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic       nextdata_n;
    logic       uppercase;
    logic [7:0] data;
    logic [7:0] ascii;
    logic       ready;
    logic       overflow;
    logic       sample;

    modport master (
        output ps2_clk, ps2_data, nextdata_n, uppercase,
        input  data, ascii, ready, overflow, sample
    );

    modport slave (
        input  ps2_clk, ps2_data, nextdata_n, uppercase,
        output data, ascii, ready, overflow, sample
    );
endinterface

// File: rtl/ps2_scan_receiver.sv
// PS/2 frame deserialiser with scancode FIFO and Set-2 ASCII translation of the head byte.
// Latency: ready rises 3 clk after the stop-bit ps2_clk fall; pop with nextdata_n low, full FIFO drops and flags overflow.
module ps2_scan_receiver #(
    parameter int FIFO_AW        = 3,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic              clk,
    input  logic              clr,
    ps2_scan_receiver_if.slave bus
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]      TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);

    logic [2:0]         sync;
    logic [3:0]         cnt;
    logic [9:0]         shift;
    logic [TW-1:0]      tmo;
    logic [FIFO_AW-1:0] w_ptr;
    logic [FIFO_AW-1:0] r_ptr;
    logic               ovf;
    logic [7:0]         mem [2**FIFO_AW];

    logic sample;
    logic frame_end;
    logic frame_ok;
    logic full;
    logic ready;
    logic push;
    logic pop;

    assign sample    = sync[2] & ~sync[1];
    assign frame_end = sample && (cnt == 4'd10);
    // shift[0] is the start bit, shift[8:1] the byte, shift[9] parity; the live ps2_data is the stop bit.
    assign frame_ok  = ~shift[0] & bus.ps2_data & (^shift[9:1]);
    assign full      = (w_ptr + PTR_ONE) == r_ptr;
    assign ready     = (w_ptr != r_ptr);
    assign push      = frame_end & frame_ok & ~full;
    assign pop       = ready & ~bus.nextdata_n;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            sync  <= 3'b111;
            cnt   <= 4'd0;
            shift <= 10'd0;
            tmo   <= '0;
            w_ptr <= '0;
            r_ptr <= '0;
            ovf   <= 1'b0;
        end else begin
            sync <= {sync[1:0], bus.ps2_clk};
            if (sample) begin
                shift <= {bus.ps2_data, shift[9:1]};
                cnt   <= (cnt == 4'd10) ? 4'd0 : cnt + 4'd1;
                tmo   <= '0;
            end else if (cnt != 4'd0) begin
                if (tmo == TMO_LAST) begin
                    cnt <= 4'd0;
                    tmo <= '0;
                end else begin
                    tmo <= tmo + TW'(1);
                end
            end else begin
                tmo <= '0;
            end
            if (push) w_ptr <= w_ptr + PTR_ONE;
            if (frame_end && frame_ok && full) ovf <= 1'b1;
            if (pop) r_ptr <= r_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[w_ptr] <= shift[8:1];
    end

    // Each entry packs {unshifted, shifted} ASCII.
    logic [15:0] pair;
    always_comb begin
        pair = 16'h0000;
        case (bus.data)
            8'h1C: pair = 16'h6141; 8'h32: pair = 16'h6242; 8'h21: pair = 16'h6343;
            8'h23: pair = 16'h6444; 8'h24: pair = 16'h6545; 8'h2B: pair = 16'h6646;
            8'h34: pair = 16'h6747; 8'h33: pair = 16'h6848; 8'h43: pair = 16'h6949;
            8'h3B: pair = 16'h6A4A; 8'h42: pair = 16'h6B4B; 8'h4B: pair = 16'h6C4C;
            8'h3A: pair = 16'h6D4D; 8'h31: pair = 16'h6E4E; 8'h44: pair = 16'h6F4F;
            8'h4D: pair = 16'h7050; 8'h15: pair = 16'h7151; 8'h2D: pair = 16'h7252;
            8'h1B: pair = 16'h7353; 8'h2C: pair = 16'h7454; 8'h3C: pair = 16'h7555;
            8'h2A: pair = 16'h7656; 8'h1D: pair = 16'h7757; 8'h22: pair = 16'h7858;
            8'h35: pair = 16'h7959; 8'h1A: pair = 16'h7A5A;
            8'h45: pair = 16'h3029; 8'h16: pair = 16'h3121; 8'h1E: pair = 16'h3240;
            8'h26: pair = 16'h3323; 8'h25: pair = 16'h3424; 8'h2E: pair = 16'h3525;
            8'h36: pair = 16'h365E; 8'h3D: pair = 16'h3726; 8'h3E: pair = 16'h382A;
            8'h46: pair = 16'h3928;
            8'h4E: pair = 16'h2D5F; 8'h55: pair = 16'h3D2B; 8'h41: pair = 16'h2C3C;
            8'h49: pair = 16'h2E3E; 8'h4A: pair = 16'h2F3F; 8'h4C: pair = 16'h3B3A;
            8'h52: pair = 16'h2722; 8'h54: pair = 16'h5B7B; 8'h5B: pair = 16'h5D7D;
            8'h5D: pair = 16'h5C7C; 8'h0E: pair = 16'h607E;
            8'h29: pair = 16'h2020; 8'h5A: pair = 16'h0D0D; 8'h66: pair = 16'h0808;
            8'h0D: pair = 16'h0909; 8'h76: pair = 16'h1B1B;
            default: pair = 16'h0000;
        endcase
    end

    assign bus.data     = mem[r_ptr];
    assign bus.ascii    = bus.uppercase ? pair[7:0] : pair[15:8];
    assign bus.ready    = ready;
    assign bus.overflow = ovf;
    assign bus.sample   = sample;
endmodule

// File: tb/tb_ps2_scan_receiver.sv
// Bench for ps2_scan_receiver: cycle-level frame driver, queue-based reference model, per-cycle compare.
module tb_ps2_scan_receiver;
    localparam int AW  = 3;
    localparam int TMO = 100;
    localparam int H   = 8;
    localparam int CAP = (1 << AW) - 1;

    logic clk = 1'b0;
    logic clr;
    ps2_scan_receiver_if bus();

    ps2_scan_receiver #(.FIFO_AW(AW), .TIMEOUT_CYCLES(TMO)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [7:0] q[$];
    bit         m_ovf = 1'b0;
    int         age = 0;
    bit         tag_next_v = 1'b0, tag_live_v = 1'b0;
    logic [7:0] tag_next_b = 8'h00, tag_live_b = 8'h00;
    bit         prev_pclk = 1'b1;
    bit         chk_en = 1'b0;
    int         n_cmp = 0, n_bad = 0;

    logic [7:0] let_codes [26] = '{8'h1C,8'h32,8'h21,8'h23,8'h24,8'h2B,8'h34,8'h33,8'h43,8'h3B,
                                   8'h42,8'h4B,8'h3A,8'h31,8'h44,8'h4D,8'h15,8'h2D,8'h1B,8'h2C,
                                   8'h3C,8'h2A,8'h1D,8'h22,8'h35,8'h1A};
    logic [7:0] dig_codes [10] = '{8'h45,8'h16,8'h1E,8'h26,8'h25,8'h2E,8'h36,8'h3D,8'h3E,8'h46};
    logic [7:0] pun_codes [11] = '{8'h4E,8'h55,8'h41,8'h49,8'h4A,8'h4C,8'h52,8'h54,8'h5B,8'h5D,8'h0E};
    logic [7:0] ctl_codes [5]  = '{8'h29,8'h5A,8'h66,8'h0D,8'h76};
    logic [7:0] ctl_vals  [5]  = '{8'h20,8'h0D,8'h08,8'h09,8'h1B};
    string dig_lo = "0123456789";
    string dig_hi = ")!@#$%^&*(";
    logic [7:0] pun_lo [11] = '{8'h2D,8'h3D,8'h2C,8'h2E,8'h2F,8'h3B,8'h27,8'h5B,8'h5D,8'h5C,8'h60};
    logic [7:0] pun_hi [11] = '{8'h5F,8'h2B,8'h3C,8'h3E,8'h3F,8'h3A,8'h22,8'h7B,8'h7D,8'h7C,8'h7E};

    function automatic logic [7:0] m_ascii(input logic [7:0] c, input logic up);
        for (int i = 0; i < 26; i++) if (c == let_codes[i]) return up ? 8'(65 + i) : 8'(97 + i);
        for (int i = 0; i < 10; i++) if (c == dig_codes[i]) return up ? dig_hi[i] : dig_lo[i];
        for (int i = 0; i < 11; i++) if (c == pun_codes[i]) return up ? pun_hi[i] : pun_lo[i];
        for (int i = 0; i < 5; i++)  if (c == ctl_codes[i]) return ctl_vals[i];
        return 8'h00;
    endfunction

    task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b want %b at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit rpop(input int pct);
        return !($urandom_range(0, 99) < pct);
    endfunction

    // One clk cycle: drive inputs, take the edge, advance the model for that edge.
    task automatic tick(input bit pc, input bit pd, input bit pn);
        bit fall, full_pre;
        fall = prev_pclk && !pc;
        prev_pclk = pc;
        bus.ps2_clk = pc;
        bus.ps2_data = pd;
        bus.nextdata_n = pn;
        @(posedge clk);
        if (!clr) begin
            full_pre = (q.size() == CAP);
            if (!pn && q.size() != 0) void'(q.pop_front());
            if (fall) begin
                age = 1;
                tag_live_v = tag_next_v;
                tag_live_b = tag_next_b;
                tag_next_v = 1'b0;
            end else if (age != 0) begin
                age = (age >= 3) ? 0 : age + 1;
            end
            if (age == 3 && tag_live_v) begin
                if (full_pre) m_ovf = 1'b1;
                else q.push_back(tag_live_b);
                tag_live_v = 1'b0;
            end
        end
        #1;
    endtask

    task automatic idle(input int n, input int pct);
        for (int k = 0; k < n; k++) tick(1'b1, 1'b1, rpop(pct));
    endtask

    task automatic pop1();
        tick(1'b1, 1'b1, 1'b0);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit bad_par, input bit bad_stop,
                              input bit bad_start, input int nbits, input int pct);
        logic [10:0] f;
        f = {~bad_stop, (~^d) ^ bad_par, d, bad_start};
        for (int i = 0; i < nbits; i++) begin
            for (int k = 0; k < H; k++) tick(1'b1, f[i], rpop(pct));
            if (i == 10) begin
                tag_next_v = (f[0] == 1'b0) && (f[10] == 1'b1) && ((^f[9:1]) == 1'b1);
                tag_next_b = f[8:1];
            end
            for (int k = 0; k < H; k++) tick(1'b0, f[i], rpop(pct));
        end
        for (int k = 0; k < H; k++) tick(1'b1, 1'b1, rpop(pct));
    endtask

    always @(negedge clk) begin
        if (chk_en && !clr) begin
            chk1("ready", bus.ready, q.size() != 0);
            chk1("overflow", bus.overflow, m_ovf);
            chk1("sample", bus.sample, age == 2);
            if (q.size() != 0) begin
                chk8("data", bus.data, q[0]);
                chk8("ascii", bus.ascii, m_ascii(q[0], bus.uppercase));
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] burst [8];
        clr = 1'b0;
        bus.ps2_clk = 1'b1;
        bus.ps2_data = 1'b1;
        bus.nextdata_n = 1'b1;
        bus.uppercase = 1'b0;
        #1 clr = 1'b1;
        #1;
        chk1("rst_ready", bus.ready, 1'b0);
        chk1("rst_overflow", bus.overflow, 1'b0);
        chk1("rst_sample", bus.sample, 1'b0);
        repeat (3) @(posedge clk);
        #1 clr = 1'b0;
        chk_en = 1'b1;

        // Basic frame and case select
        send_frame(8'h1C, 0, 0, 0, 11, 0);
        chk1("t1_ready", bus.ready, 1'b1);
        chk8("t1_data", bus.data, 8'h1C);
        chk8("t1_ascii_lo", bus.ascii, 8'h61);
        bus.uppercase = 1'b1;
        #1 chk8("t1_ascii_hi", bus.ascii, 8'h41);
        pop1();
        chk1("t1_empty", bus.ready, 1'b0);

        // Corrupt frames are discarded silently
        bus.uppercase = 1'b0;
        send_frame(8'h16, 1, 0, 0, 11, 0);
        send_frame(8'h16, 0, 1, 0, 11, 0);
        chk1("t2_ready", bus.ready, 1'b0);
        chk1("t2_overflow", bus.overflow, 1'b0);
        bus.uppercase = 1'b1;
        send_frame(8'h16, 0, 0, 0, 11, 0);
        chk8("t2_data", bus.data, 8'h16);
        chk8("t2_ascii", bus.ascii, 8'h21);
        pop1();

        // Ordering
        bus.uppercase = 1'b0;
        send_frame(8'hF0, 0, 0, 0, 11, 0);
        send_frame(8'h1C, 0, 0, 0, 11, 0);
        send_frame(8'h29, 0, 0, 0, 11, 0);
        chk8("t3_head", bus.data, 8'hF0);
        pop1();
        pop1();
        chk8("t3_data", bus.data, 8'h29);
        chk8("t3_ascii", bus.ascii, 8'h20);
        pop1();
        chk1("t3_empty", bus.ready, 1'b0);

        // Overflow
        for (int i = 0; i < 8; i++) begin
            burst[i] = 8'($urandom);
            send_frame(burst[i], 0, 0, 0, 11, 0);
        end
        chk1("t4_overflow", bus.overflow, 1'b1);
        chk8("t4_head", bus.data, burst[0]);
        for (int i = 0; i < 7; i++) pop1();
        chk1("t4_empty", bus.ready, 1'b0);
        idle(3, 0);
        chk1("t4_sticky", bus.overflow, 1'b1);

        // Timeout on a stalled partial frame
        send_frame(8'h45, 0, 0, 0, 5, 0);
        idle(TMO + 30, 0);
        send_frame(8'h45, 0, 0, 0, 11, 0);
        chk8("t5_data", bus.data, 8'h45);
        chk8("t5_ascii", bus.ascii, 8'h30);
        pop1();

        // Reset mid-frame with bytes queued
        send_frame(8'h1C, 0, 0, 0, 11, 0);
        send_frame(8'h32, 0, 0, 0, 11, 0);
        send_frame(8'h24, 0, 0, 0, 5, 0);
        #2;
        clr = 1'b1;
        bus.ps2_clk = 1'b1;
        prev_pclk = 1'b1;
        #1;
        chk1("t6_ready", bus.ready, 1'b0);
        chk1("t6_overflow", bus.overflow, 1'b0);
        q.delete();
        m_ovf = 1'b0;
        age = 0;
        tag_next_v = 1'b0;
        tag_live_v = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 clr = 1'b0;
        send_frame(8'h5A, 0, 0, 0, 11, 0);
        chk8("t6_data", bus.data, 8'h5A);
        chk8("t6_ascii", bus.ascii, 8'h0D);
        pop1();

        // Random traffic with concurrent pops and occasional corruption
        for (int i = 0; i < 40; i++) begin
            int kind;
            bus.uppercase = 1'($urandom);
            kind = $urandom_range(0, 9);
            send_frame(8'($urandom), kind == 0, kind == 1, kind == 2, 11, 25);
            idle($urandom_range(0, 10), 25);
        end
        for (int i = 0; i < 10; i++) pop1();
        chk1("t7_empty", bus.ready, 1'b0);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ps2_scan_receiver.md
Name: ps2_scan_receiver

Overview:
- PS/2 keyboard front end.
- Deserialises 11-bit PS/2 frames from the raw device clock/data lines, validates them and queues scancode bytes in a small FIFO.
- Presents the FIFO head with a ready/nextdata_n read handshake, plus a combinational Set-2 scancode-to-ASCII translation of the head byte.
- Sits between the board PS/2 pins and the keyboard decode logic that fills the character buffer RAM.

Parameters:
- FIFO_AW, 3: FIFO address width; the ring has 2^FIFO_AW slots and holds at most 2^FIFO_AW-1 bytes.
- TIMEOUT_CYCLES, 50000: clk cycles without a PS/2 falling edge, mid-frame, before the partial frame is discarded.

Ports:
- clk  input  1  system clock (50 MHz).
- clr  input  1  reset, asynchronous, active-high.
- ps2_clk  input  1  raw PS/2 clock, asynchronous to clk.
- ps2_data  input  1  raw PS/2 data.
- nextdata_n  input  1  active-low pop request.
- uppercase  input  1  selects the shifted ASCII table.
- data  output  8  scancode at the FIFO head.
- ascii  output  8  ASCII translation of data.
- ready  output  1  FIFO non-empty.
- overflow  output  1  sticky flag: a valid frame was dropped because the FIFO was full.
- sample  output  1  one-cycle pulse on each detected PS/2 falling edge.

Behaviour:
- Reset (clr=1, asynchronous) clears:
  - the 3-stage ps2_clk synchroniser (to 1s);
  - the bit counter, shift register, timeout counter, both pointers and overflow.
- Outputs after reset: ready=0, sample=0, overflow=0. data and ascii are don't-care while ready=0.
- Synchroniser: sync <= {sync[1:0], ps2_clk} each clk. sample = sync[2] & ~sync[1].
- Bit capture: on each sample, shift ps2_data into a 10-bit register LSB-first and increment the bit count (0..10).
- Frame completion: on the sample where count==10, ps2_data is the stop bit, and count returns to 0. The frame is valid when all of these hold:
  - start bit == 0;
  - stop bit == 1;
  - XOR of the 8 data bits and the parity bit == 1 (odd parity).
- Invalid frames are silently discarded. No flag is raised.
- Valid frame handling:
  - FIFO not full: write the byte to fifo[w_ptr], then w_ptr++.
  - FIFO full (w_ptr+1 == r_ptr, modulo 2^FIFO_AW): drop the byte and set overflow=1. overflow stays set until clr.
- Timeout: while count != 0, a counter increments each clk without sample. When it reaches TIMEOUT_CYCLES, count is forced to 0 and the partial frame is dropped. The counter clears on every sample and whenever count==0.
- Read handshake:
  - ready = (w_ptr != r_ptr), combinational from registered pointers.
  - data = fifo[r_ptr].
  - On any clk edge where ready==1 and nextdata_n==0, r_ptr++.
  - A pop with ready==0 is ignored.
  - A consumer holding nextdata_n low pops one byte per cycle.
- Simultaneous push and pop in the same cycle: both take effect. The full check uses the pre-pop r_ptr, so the push is dropped if the FIFO was full at that edge.
- Pointers wrap modulo 2^FIFO_AW.
- Latency: ready rises on the clk edge after the stop-bit sample, i.e. 3-4 clk after the falling ps2_clk edge of the stop bit.
- ascii is combinational from data and uppercase. Unlisted codes give 0x00.
  - Letters: 1C a, 32 b, 21 c, 23 d, 24 e, 2B f, 34 g, 33 h, 43 i, 3B j, 42 k, 4B l, 3A m, 31 n, 44 o, 4D p, 15 q, 2D r, 1B s, 2C t, 3C u, 2A v, 1D w, 22 x, 35 y, 1A z. Lowercase 0x61.. when uppercase=0; 0x41.. when uppercase=1.
  - Digits: 45 0, 16 1, 1E 2, 26 3, 25 4, 2E 5, 36 6, 3D 7, 3E 8, 46 9. Shifted to ) ! @ # $ % ^ & * ( respectively.
  - Punctuation: 4E -, 55 =, 41 ",", 49 ., 4A /, 4C ;, 52 ', 54 [, 5B ], 5D \, 0E `. Shifted to _ + < > ? : " { } | ~.
  - Control: 29 space 0x20, 5A 0x0D, 66 0x08, 0D 0x09, 76 0x1B. These are unaffected by uppercase.

Test Plan:
- Valid frame 0x1C (parity bit 0), ps2_clk at 12 kHz, uppercase=0 -> ready=1, data=0x1C, ascii=0x61. Set uppercase=1 -> ascii=0x41. Pulse nextdata_n low 1 cycle -> ready=0.
- Frame 0x16 with wrong parity, then a frame with stop bit 0 -> ready stays 0, overflow=0. Then valid 0x16 with uppercase=1 -> data=0x16, ascii=0x21.
- Send 0xF0, 0x1C, 0x29 without popping -> pops return 0xF0, 0x1C, 0x29 in order; ascii for 0x29 = 0x20; ready=0 after the 3rd pop.
- Send 8 valid frames with no pops -> first 7 queued, 8th dropped, overflow=1. Drain 7 -> values in order. overflow stays 1 until clr.
- Stop ps2_clk after 5 bits for > TIMEOUT_CYCLES, then send a full valid 0x45 -> data=0x45, ascii=0x30.
- Assert clr mid-frame and with 2 bytes queued -> ready=0, overflow=0 immediately; next valid frame is received correctly.
